// File: rtl/mem_byte_sequencer_pkg.sv
// Shared encodings and helpers for the byte-serialising external bus sequencer.
package mem_byte_sequencer_pkg;

  localparam int AddrLen = 32;
  localparam int RegLen  = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_READ    = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_IO_WAIT = 2'd3;

  localparam logic [1:0] IO_SEL = 2'b11;

  function automatic logic is_io_addr(input logic [AddrLen-1:0] a);
    return a[17:16] == IO_SEL;
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

  // Little-endian lanes already assembled; extend from the top byte of the access.
  function automatic logic [RegLen-1:0] extend_load(input logic [RegLen-1:0] lanes,
                                                    input logic [1:0] size,
                                                    input logic uns);
    logic fill;
    fill = 1'b0;
    case (size)
      SIZE_BYTE: begin
        fill = !uns && lanes[7];
        return {{24{fill}}, lanes[7:0]};
      end
      SIZE_HALF: begin
        fill = !uns && lanes[15];
        return {{16{fill}}, lanes[15:0]};
      end
      default: return lanes;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_sequencer.sv
// Serialises one 32-bit load/store into byte accesses; load N+2 cycles, store N+1, rdy low freezes.
// MEM_BYTE_SEQ_IO_GUARD_EN: IO stores wait for io_buffer_full low before every byte.
module mem_byte_sequencer
  import mem_byte_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  input  logic        flush_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  logic [1:0]         state;
  logic [2:0]         k;
  logic [2:0]         n_bytes;
  logic [AddrLen-1:0] addr;
  logic [1:0]         size;
  logic               uns;
  logic [RegLen-1:0]  wdata;
  logic [RegLen-1:0]  lanes;
  logic [RegLen-1:0]  lanes_nxt;
  logic               cap_vld;
  logic [1:0]         cap_idx;
  logic               accept;
  logic               last_byte;
  logic [AddrLen-1:0] byte_addr;

  assign n_bytes     = size_bytes(size);
  assign req_ready_o = (state == ST_IDLE) && !flush_i && rdy;
  assign accept      = req_valid_i && req_ready_o;
  assign byte_addr   = addr + {{(AddrLen-3){1'b0}}, k};
  assign last_byte   = (k == n_bytes - 3'd1);

  always_comb begin
    lanes_nxt = lanes;
    if (cap_vld) lanes_nxt[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  // k == n_bytes in READ is the final capture cycle; nothing is issued then.
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if (state == ST_READ && k != n_bytes) begin
      mem_a = byte_addr;
    end else if (state == ST_WRITE) begin
      mem_a    = byte_addr;
      mem_dout = wdata[{k[1:0], 3'b000} +: 8];
      mem_wr   = rdy;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      k       <= '0;
      addr    <= '0;
      size    <= '0;
      uns     <= 1'b0;
      wdata   <= '0;
      lanes   <= '0;
      cap_vld <= 1'b0;
      cap_idx <= '0;
      done_o  <= 1'b0;
      rdata_o <= '0;
    end else begin
      done_o  <= 1'b0;
      lanes   <= lanes_nxt;
      cap_vld <= 1'b0;
      if (rdy) begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              addr  <= req_addr_i;
              size  <= req_size_i;
              uns   <= req_unsigned_i;
              wdata <= req_wdata_i;
              k     <= '0;
              if (!req_wr_i) state <= ST_READ;
`ifdef MEM_BYTE_SEQ_IO_GUARD_EN
              else if (is_io_addr(req_addr_i)) state <= ST_IO_WAIT;
`endif
              else state <= ST_WRITE;
            end
          end
          ST_READ: begin
            if (flush_i) begin
              state <= ST_IDLE;
              k     <= '0;
            end else if (k == n_bytes) begin
              rdata_o <= extend_load(lanes_nxt, size, uns);
              done_o  <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              cap_vld <= 1'b1;
              cap_idx <= k[1:0];
              k       <= k + 3'd1;
            end
          end
          ST_WRITE: begin
            if (last_byte) begin
              done_o <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              k <= k + 3'd1;
`ifdef MEM_BYTE_SEQ_IO_GUARD_EN
              // The full flag lags a cycle, so re-check it before every IO byte.
              if (is_io_addr(addr)) state <= ST_IO_WAIT;
`endif
            end
          end
          ST_IO_WAIT: begin
            if (!io_buffer_full) state <= ST_WRITE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
